// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite memory slave backing a small byte-addressed window with a
// register-file SRAM of 2**(ADDR_BITS-2) 32-bit words. It supports pipelined
// address/data phases, a fixed number of wait states on every OKAY data phase,
// byte-lane writes and the two-cycle ERROR response.
//
// Parameters:
//   ADDR_BITS   byte-address width of the window (words = 2**(ADDR_BITS-2))
//   WAIT_CYCLES wait states inserted in every OKAY data phase (0..15)
//
// Ports:
//   a_clk     in   1  system clock, rising edge
//   a_resetn  in   1  asynchronous active-low reset
//   h_addr    in  32  address-phase byte address
//   h_burst   in   3  burst type (accepted, unused: every beat has its own address)
//   h_size    in   3  0=byte, 1=half, 2=word, others illegal
//   h_trans   in   2  IDLE/BUSY/NONSEQ/SEQ
//   h_write   in   1  1=write, sampled in address phase
//   h_wdata   in  32  write data, valid in data phase
//   h_wstrb   in   4  byte enables, valid in data phase
//   h_rdata   out 32  registered read data
//   h_ready   out  1  1=data phase completes this cycle
//   h_resp    out  1  0=OKAY, 1=ERROR
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
   parameter int ADDR_BITS   = 6,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        a_clk,
   input  logic        a_resetn,
   input  logic [31:0] h_addr,
   input  logic [2:0]  h_burst,
   input  logic [2:0]  h_size,
   input  logic [1:0]  h_trans,
   input  logic        h_write,
   input  logic [31:0] h_wdata,
   input  logic [3:0]  h_wstrb,
   output logic [31:0] h_rdata,
   output logic        h_ready,
   output logic        h_resp
);

   localparam int         IDX_BITS  = ADDR_BITS - 2;
   localparam int         WORDS     = 2 ** IDX_BITS;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   // An active transfer is illegal when it leaves the window, uses an
   // unsupported size, or is misaligned for its size.
   function automatic logic is_illegal(input logic [31:0] addr, input logic [2:0] size);
      logic bad;
      bad = |addr[31:ADDR_BITS];
      case (size)
         3'd0:    bad = bad;
         3'd1:    bad = bad | addr[0];
         3'd2:    bad = bad | (|addr[1:0]);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte lanes covered by a transfer of the given size at the given address.
   function automatic logic [3:0] size_lanes(input logic [1:0] addr_lo, input logic [2:0] size);
      logic [3:0] lanes;
      case (size)
         3'd0:    lanes = 4'b0001 << addr_lo;
         3'd1:    lanes = 4'b0011 << addr_lo;
         3'd2:    lanes = 4'b1111;
         default: lanes = 4'b0000;
      endcase
      return lanes;
   endfunction

   // Replace the enabled bytes of a stored word with write data.
   function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  en);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = en[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
      end
      return res;
   endfunction

   state_t              state_r;
   state_t              state_s;
   logic [3:0]          cnt_r;
   logic [3:0]          cnt_s;
   logic                ready_r;
   logic                resp_r;
   logic [31:0]         rdata_r;
   logic [31:0]         mem_r [WORDS];

   // Data-phase descriptor captured at address-phase acceptance.
   logic                dp_write_r;
   logic [IDX_BITS-1:0] dp_idx_r;
   logic [3:0]          dp_lanes_r;

   logic                active_s;
   logic                illegal_s;
   logic                rd_load_s;
   logic                commit_s;
   logic [IDX_BITS-1:0] a_idx_s;
   logic [31:0]         merged_s;
   logic [31:0]         rd_word_s;
   logic                unused_s;

   assign active_s  = h_trans[1];
   assign illegal_s = is_illegal(h_addr, h_size);
   assign a_idx_s   = h_addr[ADDR_BITS-1:2];
   // A new address phase is only sampled while the current data phase completes.
   assign rd_load_s = ready_r & active_s & ~illegal_s & ~h_write;
   assign commit_s  = ready_r & dp_write_r;
   assign merged_s  = merge_word(mem_r[dp_idx_r], h_wdata, h_wstrb & dp_lanes_r);
   assign unused_s  = ^{h_burst, h_trans[0]};

   assign h_rdata = rdata_r;
   assign h_ready = ready_r;
   assign h_resp  = resp_r;

   // Read word source: forward the committing write when it hits the same word.
   always_comb begin
      rd_word_s = mem_r[a_idx_s];
      if (commit_s && (a_idx_s == dp_idx_r)) begin
         rd_word_s = merged_s;
      end else begin
         rd_word_s = mem_r[a_idx_s];
      end
   end

   // Next-state and wait-counter logic of the data-phase FSM.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_IDLE, ST_ERR2: begin
            if (active_s) begin
               if (illegal_s) begin
                  state_s = ST_ERR1;
               end else if (WAIT_LOAD != 4'd0) begin
                  state_s = ST_WAIT;
                  cnt_s   = WAIT_LOAD;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_s = cnt_r - 4'd1;
            if (cnt_r <= 4'd1) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_ERR1: begin
            state_s = ST_ERR2;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
         end
      endcase
   end

   // FSM state, wait counter and registered h_ready/h_resp decoded from next state.
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         ready_r <= 1'b1;
         resp_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         ready_r <= (state_s != ST_WAIT) && (state_s != ST_ERR1);
         resp_r  <= (state_s == ST_ERR1) || (state_s == ST_ERR2);
      end
   end

   // Capture the data-phase descriptor when an address phase is accepted.
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         dp_write_r <= 1'b0;
         dp_idx_r   <= {IDX_BITS{1'b0}};
         dp_lanes_r <= 4'b0000;
      end else if (ready_r) begin
         dp_write_r <= active_s & ~illegal_s & h_write;
         dp_idx_r   <= a_idx_s;
         dp_lanes_r <= size_lanes(h_addr[1:0], h_size);
      end
   end

   // Storage array: byte-lane commit on the completing edge of a legal write.
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         for (int i = 0; i < WORDS; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
      end else if (commit_s) begin
         mem_r[dp_idx_r] <= merged_s;
      end
   end

   // Read data register: loaded on legal read acceptance, held otherwise.
   always_ff @(posedge a_clk or negedge a_resetn) begin
      if (!a_resetn) begin
         rdata_r <= 32'h0000_0000;
      end else if (rd_load_s) begin
         rdata_r <= rd_word_s;
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
//
// Drives two slaves (zero wait states and two wait states) with directed AHB
// transfers. A transaction-level model of each slave is compared against the
// DUT outputs on every falling clock edge; literal expectations at key points
// pin the model itself.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;

   localparam logic [1:0] T_IDLE   = 2'b00;
   localparam logic [1:0] T_BUSY   = 2'b01;
   localparam logic [1:0] T_NONSEQ = 2'b10;
   localparam logic [1:0] T_SEQ    = 2'b11;

   logic        a_clk;
   logic [1:0]  rstn_v;
   logic [31:0] addr_v  [2];
   logic [2:0]  burst_v [2];
   logic [2:0]  size_v  [2];
   logic [1:0]  trans_v [2];
   logic        write_v [2];
   logic [31:0] wdata_v [2];
   logic [3:0]  wstrb_v [2];

   logic [31:0] rdata0, rdata1;
   logic        ready0, ready1, resp0, resp1;
   logic [31:0] rdata_v [2];
   logic        ready_v [2];
   logic        resp_v  [2];

   logic [31:0] exp_rdata_v [2];
   logic        exp_ready_v [2];
   logic        exp_resp_v  [2];

   int   n_total = 0;
   int   n_pass  = 0;
   logic cmp_on  = 1'b0;

   assign rdata_v[0] = rdata0;
   assign rdata_v[1] = rdata1;
   assign ready_v[0] = ready0;
   assign ready_v[1] = ready1;
   assign resp_v[0]  = resp0;
   assign resp_v[1]  = resp1;

   ahb_sram_slave #(.ADDR_BITS(6), .WAIT_CYCLES(0)) dut0 (
      .a_clk(a_clk), .a_resetn(rstn_v[0]),
      .h_addr(addr_v[0]), .h_burst(burst_v[0]), .h_size(size_v[0]),
      .h_trans(trans_v[0]), .h_write(write_v[0]), .h_wdata(wdata_v[0]),
      .h_wstrb(wstrb_v[0]), .h_rdata(rdata0), .h_ready(ready0), .h_resp(resp0)
   );

   ahb_sram_slave #(.ADDR_BITS(6), .WAIT_CYCLES(2)) dut1 (
      .a_clk(a_clk), .a_resetn(rstn_v[1]),
      .h_addr(addr_v[1]), .h_burst(burst_v[1]), .h_size(size_v[1]),
      .h_trans(trans_v[1]), .h_write(write_v[1]), .h_wdata(wdata_v[1]),
      .h_wstrb(wstrb_v[1]), .h_rdata(rdata1), .h_ready(ready1), .h_resp(resp1)
   );

   initial a_clk = 1'b0;
   always #5 a_clk = ~a_clk;

   // Transaction-level model: the current data phase is OKAY (kind 1),
   // ERROR (kind 2) or empty (kind 0), with a count of cycles spent in it.
   for (genvar g = 0; g < 2; g++) begin : mdl
      localparam int W = (g == 0) ? 0 : 2;
      logic [31:0] mem_m [16];
      int          kind_m;
      int          elapsed_m;
      logic        wr_m;
      int          idx_m;
      logic [3:0]  lanes_m;
      logic [31:0] rdata_m;
      logic [31:0] merged;
      logic        commit;
      logic [31:0] a;
      int          nbytes;
      int          lo;
      logic        legal;
      logic [3:0]  ln;

      assign exp_ready_v[g] = (kind_m == 1) ? (elapsed_m >= W) :
                              (kind_m == 2) ? (elapsed_m >= 1) : 1'b1;
      assign exp_resp_v[g]  = (kind_m == 2);
      assign exp_rdata_v[g] = rdata_m;

      always @(posedge a_clk or negedge rstn_v[g]) begin
         if (!rstn_v[g]) begin
            for (int i = 0; i < 16; i++) mem_m[i] <= 32'h0;
            kind_m    <= 0;
            elapsed_m <= 0;
            wr_m      <= 1'b0;
            idx_m     <= 0;
            lanes_m   <= 4'h0;
            rdata_m   <= 32'h0;
         end else if (exp_ready_v[g]) begin
            merged = mem_m[idx_m];
            commit = (kind_m == 1) && wr_m;
            if (commit) begin
               for (int b = 0; b < 4; b++)
                  if (lanes_m[b] && wstrb_v[g][b]) merged[8*b +: 8] = wdata_v[g][8*b +: 8];
               mem_m[idx_m] <= merged;
            end
            if (trans_v[g][1]) begin
               a      = addr_v[g];
               nbytes = 1 << size_v[g];
               lo     = int'(a[1:0]);
               legal  = (a < 32'd64) && (size_v[g] <= 3'd2) && ((int'(a[5:0]) % nbytes) == 0);
               for (int b = 0; b < 4; b++) ln[b] = (b >= lo) && (b < lo + nbytes);
               kind_m    <= legal ? 1 : 2;
               elapsed_m <= 0;
               wr_m      <= legal && write_v[g];
               idx_m     <= int'(a[5:2]);
               lanes_m   <= ln;
               if (legal && !write_v[g])
                  rdata_m <= (commit && int'(a[5:2]) == idx_m) ? merged : mem_m[a[5:2]];
            end else begin
               kind_m <= 0;
            end
         end else begin
            elapsed_m <= elapsed_m + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Cycle-by-cycle comparison of both DUTs against the model.
   always @(negedge a_clk) begin
      if (cmp_on) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_ready", d), {31'h0, ready_v[d]}, {31'h0, exp_ready_v[d]});
            chk($sformatf("dut%0d_resp", d),  {31'h0, resp_v[d]},  {31'h0, exp_resp_v[d]});
            chk($sformatf("dut%0d_rdata", d), rdata_v[d], exp_rdata_v[d]);
         end
      end
   end

   // One bus beat: drives an address phase together with the write data of the
   // data phase in progress, then waits (bounded) for that data phase to complete.
   task automatic ahb(input int d, input logic [1:0] tr, input logic wr,
                      input logic [31:0] ad, input logic [2:0] sz,
                      input logic [31:0] wd, input logic [3:0] st,
                      output int waits, output logic rsp);
      logic done;
      trans_v[d] = tr;
      write_v[d] = wr;
      addr_v[d]  = ad;
      size_v[d]  = sz;
      wdata_v[d] = wd;
      wstrb_v[d] = st;
      burst_v[d] = 3'd1;
      waits = 0;
      rsp   = 1'b0;
      done  = 1'b0;
      while (!done) begin
         @(negedge a_clk);
         if (ready_v[d]) begin
            rsp  = resp_v[d];
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 32) begin
               chk("ready_timeout", 32'd0, 32'd1);
               done = 1'b1;
            end
         end
      end
      @(posedge a_clk);
      #1;
   endtask

   initial begin
      int   w;
      logic r;
      rstn_v = 2'b11;
      for (int d = 0; d < 2; d++) begin
         addr_v[d]  = 32'h0;
         burst_v[d] = 3'd0;
         size_v[d]  = 3'd0;
         trans_v[d] = T_IDLE;
         write_v[d] = 1'b0;
         wdata_v[d] = 32'h0;
         wstrb_v[d] = 4'h0;
      end
      #2 rstn_v = 2'b00;
      #1 cmp_on = 1'b1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", {31'h0, ready_v[d]}, 32'd1);
         chk("rst_resp",  {31'h0, resp_v[d]},  32'd0);
         chk("rst_rdata", rdata_v[d], 32'h0000_0000);
      end
      repeat (2) @(negedge a_clk);
      rstn_v = 2'b11;
      @(posedge a_clk);
      #1;

      // Read after reset returns zero, zero wait.
      ahb(0, T_NONSEQ, 1'b0, 32'h0C, 3'd2, 32'h0, 4'h0, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0, 4'h0, w, r);
      chk("rd0c_rdata", rdata_v[0], 32'h0000_0000);
      chk("rd0c_waits", w, 32'd0);
      chk("rd0c_resp",  {31'h0, r}, 32'd0);

      // Word write then read (read sampled in the write's data phase).
      ahb(0, T_NONSEQ, 1'b1, 32'h08, 3'd2, 32'h0,         4'h0, w, r);
      ahb(0, T_NONSEQ, 1'b0, 32'h08, 3'd2, 32'hDEADBEEF, 4'hF, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0,         4'h0, w, r);
      chk("wr08_rdata", rdata_v[0], 32'hDEADBEEF);

      // Byte write 0x11 at 0x09.
      ahb(0, T_NONSEQ, 1'b1, 32'h09, 3'd0, 32'h0,         4'h0, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0000_1100, 4'b0010, w, r);
      ahb(0, T_NONSEQ, 1'b0, 32'h08, 3'd2, 32'h0,         4'h0, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0,         4'h0, w, r);
      chk("byte09_rdata", rdata_v[0], 32'hDEAD11EF);

      // Byte write with all strobes set: only the size lane may change.
      ahb(0, T_NONSEQ, 1'b1, 32'h09, 3'd0, 32'h0,         4'h0, w, r);
      ahb(0, T_NONSEQ, 1'b0, 32'h08, 3'd2, 32'h22222222, 4'hF, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0,         4'h0, w, r);
      chk("bytelane_rdata", rdata_v[0], 32'hDEAD22EF);

      // Back-to-back write/read of 0x10 with forwarding.
      ahb(0, T_NONSEQ, 1'b1, 32'h10, 3'd2, 32'h0,         4'h0, w, r);
      ahb(0, T_NONSEQ, 1'b0, 32'h10, 3'd2, 32'h12345678, 4'hF, w, r);
      chk("fwd_wr_waits", w, 32'd0);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0,         4'h0, w, r);
      chk("fwd_rdata", rdata_v[0], 32'h12345678);
      chk("fwd_rd_waits", w, 32'd0);

      // Out-of-range read: ERROR pair, rdata held.
      ahb(0, T_NONSEQ, 1'b0, 32'h40, 3'd2, 32'h0, 4'h0, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0, 4'h0, w, r);
      chk("oor_waits", w, 32'd1);
      chk("oor_resp",  {31'h0, r}, 32'd1);
      chk("oor_rdata", rdata_v[0], 32'h12345678);

      // Misaligned halfword write: ERROR pair, memory unchanged.
      ahb(0, T_NONSEQ, 1'b1, 32'h03, 3'd1, 32'h0,         4'h0, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'hFFFFFFFF, 4'hF, w, r);
      chk("mis_waits", w, 32'd1);
      chk("mis_resp",  {31'h0, r}, 32'd1);
      ahb(0, T_NONSEQ, 1'b0, 32'h00, 3'd2, 32'h0, 4'h0, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0, 4'h0, w, r);
      chk("mis_mem", rdata_v[0], 32'h0000_0000);

      // Illegal size is an ERROR too.
      ahb(0, T_NONSEQ, 1'b0, 32'h00, 3'd3, 32'h0, 4'h0, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0, 4'h0, w, r);
      chk("size3_resp", {31'h0, r}, 32'd1);

      // BUSY and IDLE beats inside a burst: no side effects.
      ahb(0, T_NONSEQ, 1'b0, 32'h08, 3'd2, 32'h0,         4'h0, w, r);
      ahb(0, T_BUSY,   1'b1, 32'h0C, 3'd2, 32'h0,         4'h0, w, r);
      ahb(0, T_IDLE,   1'b1, 32'h10, 3'd2, 32'hFFFFFFFF, 4'hF, w, r);
      chk("busy_rdata", rdata_v[0], 32'hDEAD22EF);
      chk("busy_waits", w, 32'd0);
      chk("busy_resp",  {31'h0, r}, 32'd0);
      ahb(0, T_SEQ,    1'b0, 32'h10, 3'd2, 32'hFFFFFFFF, 4'hF, w, r);
      ahb(0, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0,         4'h0, w, r);
      chk("busy_mem", rdata_v[0], 32'h12345678);

      // Two wait states: write then read back.
      ahb(1, T_NONSEQ, 1'b1, 32'h00, 3'd2, 32'h0,         4'h0, w, r);
      ahb(1, T_IDLE,   1'b0, 32'h0,  3'd0, 32'hA5A5A5A5, 4'hF, w, r);
      chk("ws_wr_waits", w, 32'd2);
      ahb(1, T_NONSEQ, 1'b0, 32'h00, 3'd2, 32'h0, 4'h0, w, r);
      ahb(1, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0, 4'h0, w, r);
      chk("ws_rd_waits", w, 32'd2);
      chk("ws_rdata", rdata_v[1], 32'hA5A5A5A5);

      // Reset during the first wait cycle of a write aborts it.
      ahb(1, T_NONSEQ, 1'b1, 32'h00, 3'd2, 32'h0, 4'h0, w, r);
      trans_v[1] = T_IDLE;
      wdata_v[1] = 32'h5A5A5A5A;
      wstrb_v[1] = 4'hF;
      rstn_v[1]  = 1'b0;
      #1;
      chk("abort_ready", {31'h0, ready_v[1]}, 32'd1);
      chk("abort_resp",  {31'h0, resp_v[1]},  32'd0);
      @(negedge a_clk);
      rstn_v[1] = 1'b1;
      @(posedge a_clk);
      #1;
      ahb(1, T_NONSEQ, 1'b0, 32'h00, 3'd2, 32'h0, 4'h0, w, r);
      ahb(1, T_IDLE,   1'b0, 32'h0,  3'd0, 32'h0, 4'h0, w, r);
      chk("abort_mem", rdata_v[1], 32'h0000_0000);

      repeat (2) @(posedge a_clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
